// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit processor front end.
package cpu_pkg;

  // Instruction memory geometry: 1024 words of 16 bits.
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  // Opcode field position within an instruction word.
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 13;

  // HALT is opcode 111 with every other bit zero.
  localparam logic [2:0]         OPCODE_HALT = 3'b111;
  localparam logic [INSTR_W-1:0] HALT_INSTR  = {OPCODE_HALT, {(OPCODE_LO){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// memory and presents one buffered instruction to decode over valid/ready.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; redirect only reloads the PC
//   RUN    | fetching one word per cycle whenever the buffer can accept
//   HALTED | HALT fetched; buffer drains, only redirect or reset leaves
module instr_fetch_unit #(
  parameter int                  ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                  INSTR_W    = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = cpu_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic               pc_wrapped,
  output logic [15:0]        instr_count
);

  import cpu_pkg::fetch_state_t;
  import cpu_pkg::IDLE;
  import cpu_pkg::RUN;
  import cpu_pkg::HALTED;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_carry;
  logic              transfer;
  logic              fetch;
  logic              is_halt;

  assign imem_addr = pc;
  assign transfer  = out_valid & out_ready;

  // A fetch needs RUN, no redirect this cycle, and room in the buffer
  // (empty, or its current entry leaving this cycle).
  assign fetch   = (state == RUN) & ~redirect_valid & (~out_valid | out_ready);
  assign is_halt = (imem_instr == HALT_INSTR);

  // Carry out of the increment marks the 1023 -> 0 wrap.
  assign {pc_carry, pc_inc} = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state decode; redirect pulls HALTED back into RUN, IDLE still needs start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)           state_next = RUN;
      RUN:     if (fetch && is_halt) state_next = HALTED;
      HALTED:  if (redirect_valid)  state_next = RUN;
      default:                      state_next = IDLE;
    endcase
  end

  // State register with halted registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALTED);
    end
  end

  // PC, fetch buffer and wrap flag; redirect wins over fetch and drops the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      pc_wrapped <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      out_valid  <= 1'b0;
      pc_wrapped <= 1'b0;
    end else if (fetch) begin
      out_instr <= imem_instr;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc_inc;
      if (pc_carry) begin
        pc_wrapped <= 1'b1;
      end
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of instructions handed to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'd0;
    end else if (transfer && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run.
// The expected delivery stream is a list of (pc, word) pairs walked through
// memory from each start/redirect point until a HALT word.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [15:0] HALT = 16'hE000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_ready;
  logic [9:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [9:0]  out_pc;
  logic        halted;
  logic        pc_wrapped;
  logic [15:0] instr_count;

  logic [15:0] mem [1024];

  typedef struct packed {
    logic        marker;
    logic [9:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_count;
  bit          model_idle;
  logic [9:0]  model_pc;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .pc_wrapped     (pc_wrapped),
    .instr_count    (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == HALT) w = 16'h1234;
    return w;
  endfunction

  // Expected stream from address a: consecutive words up to and including HALT.
  task automatic push_segment(input logic [9:0] a);
    exp_t e;
    for (int i = 0; i < 1024; i++) begin
      e.marker = 1'b0;
      e.pc     = a;
      e.instr  = mem[a];
      q.push_back(e);
      if (mem[a] == HALT) break;
      a = a + 10'd1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    if (model_idle) begin
      push_segment(model_pc);
      model_idle = 1'b0;
    end
    step();
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [9:0] a, input bit with_start);
    exp_t m;
    redirect_valid = 1'b1;
    redirect_pc    = a;
    start          = with_start;
    m.marker = 1'b1;
    m.pc     = '0;
    m.instr  = '0;
    q.push_back(m);
    if (!model_idle || with_start) push_segment(a);
    if (with_start) model_idle = 1'b0;
    model_pc = a;
    step();
    redirect_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic do_async_reset();
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_wrapped", pc_wrapped, 0);
    model_idle = 1'b1;
    model_pc   = 10'd0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_halt(input string name, input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (halted && !out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_halt_reached"}, ok, 1);
  endtask

  task automatic wait_pc(input logic [9:0] target, input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (out_valid && out_pc == target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_pc_reached", ok, 1);
  endtask

  // Scoreboard monitor: every transfer must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_count = 16'd0;
    end else begin
      chk("instr_count", instr_count, exp_count);
      if (out_valid && out_ready) begin
        if (q.size() == 0 || q[0].marker) begin
          total++;
          bad++;
          $display("FAIL unexpected_transfer: got out_pc=%0d out_instr=%0h expected no transfer at %0t",
                   out_pc, out_instr, $time);
        end else begin
          mon_e = q.pop_front();
          chk("xfer_pc", out_pc, mon_e.pc);
          chk("xfer_instr", out_instr, mon_e.instr);
          if (mon_e.pc == 10'd1023) chk("wrapped_after_1023", pc_wrapped, 1);
        end
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      end
      if (redirect_valid) begin
        while (q.size() > 0) begin
          mon_e = q.pop_front();
          if (mon_e.marker) break;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    model_idle = 1'b1;
    model_pc = 10'd0;
    exp_count = 16'd0;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    mem[6]   = HALT;
    mem[103] = HALT;
    mem[25]  = HALT;
    mem[55]  = HALT;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_instr", out_instr, 0);
    chk("reset_out_pc", out_pc, 0);
    chk("reset_halted", halted, 0);
    chk("reset_wrapped", pc_wrapped, 0);
    chk("reset_count", instr_count, 0);
    chk("reset_imem_addr", imem_addr, 0);
    #10 rst_n = 1'b1;
    step();

    // Straight-line program 0..6 ending in HALT, decode always ready.
    out_ready = 1'b1;
    do_start();
    chk("start_no_valid_yet", out_valid, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("seq_valid", out_valid, 1);
      chk("seq_pc", out_pc, k);
      chk("seq_instr", out_instr, mem[k]);
    end
    chk("halted_with_halt_offered", halted, 1);
    step();
    chk("after_halt_valid", out_valid, 0);
    chk("after_halt_halted", halted, 1);
    chk("after_halt_count", instr_count, 7);

    // Backpressure on word 2 for three cycles.
    do_redirect(10'd0, 1'b0);
    chk("redir_leaves_halt", halted, 0);
    chk("redir_bubble", out_valid, 0);
    wait_pc(10'd2, 10);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", out_pc, 2);
      chk("bp_instr", out_instr, mem[2]);
      chk("bp_imem_addr", imem_addr, 3);
      step();
    end
    chk("bp_pc_end", out_pc, 2);
    out_ready = 1'b1;
    step();
    chk("bp_resume_pc", out_pc, 3);
    chk("bp_count", instr_count, 10);

    // Redirect while word 3 is being accepted.
    do_redirect(10'd100, 1'b0);
    chk("redir_bubble_valid", out_valid, 0);
    chk("redir_counts_word3", instr_count, 11);
    step();
    chk("redir_target_valid", out_valid, 1);
    chk("redir_target_pc", out_pc, 100);
    chk("redir_target_instr", out_instr, mem[100]);
    wait_halt("seg100", 20);
    chk("no_wrap_yet", pc_wrapped, 0);

    // Wrap through 1022, 1023, 0.
    do_redirect(10'd1022, 1'b0);
    step();
    chk("wrap_pc_1022", out_pc, 1022);
    chk("wrap_flag_1022", pc_wrapped, 0);
    step();
    chk("wrap_pc_1023", out_pc, 1023);
    chk("wrap_flag_1023", pc_wrapped, 1);
    step();
    chk("wrap_pc_0", out_pc, 0);
    chk("wrap_flag_0", pc_wrapped, 1);
    wait_halt("wrap", 20);

    // start is ignored in HALTED; redirect restarts and clears the wrap flag.
    do_start();
    for (int i = 0; i < 2; i++) begin
      chk("halt_start_halted", halted, 1);
      chk("halt_start_valid", out_valid, 0);
      chk("halt_start_addr", imem_addr, 7);
      step();
    end
    do_redirect(10'd20, 1'b0);
    chk("halt_redir_halted", halted, 0);
    chk("halt_redir_wrapped", pc_wrapped, 0);
    step();
    chk("halt_redir_pc20", out_pc, 20);
    step();
    chk("halt_redir_pc21", out_pc, 21);

    // Asynchronous reset mid-stream.
    do_async_reset();
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_addr", imem_addr, 0);
      step();
    end
    do_start();
    chk("restart_bubble", out_valid, 0);
    step();
    chk("restart_pc", out_pc, 0);
    chk("restart_count", instr_count, 0);
    wait_halt("restart", 20);

    // Start and redirect together in IDLE.
    do_async_reset();
    do_redirect(10'd50, 1'b1);
    chk("start_redir_bubble", out_valid, 0);
    step();
    chk("start_redir_pc", out_pc, 50);
    wait_halt("start_redir", 20);

    // Randomized traffic with sparse HALT words.
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : rand_word();
    mem[512] = HALT;
    do_redirect(10'($urandom), 1'b0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 39);
      if (r == 0) do_redirect(10'($urandom), 1'b0);
      else if (r == 1) do_start();
      else step();
    end
    out_ready = 1'b1;
    do_redirect(10'($urandom), 1'b0);
    wait_halt("random_drain", 1100);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader side of the 16-bit processor's instruction memory.
- Holds the program counter (PC) and drives the memory address; the memory returns the instruction combinationally in the same cycle.
- Registers the fetched instruction and its PC into a one-entry fetch buffer, offered to decode over a valid/ready handshake.
- Supports start, branch/jump redirect, HALT detection, PC wrap-around, and a saturating count of delivered instructions.

Parameters:
- ADDR_W, 10, instruction memory address width (1024 words).
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value after reset.
- HALT_INSTR, 16'hE000, encoding that stops fetching (opcode 111, all other bits zero).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  single-cycle pulse; begins fetching from IDLE.
- imem_addr  output  ADDR_W  address to instruction memory; always equals the PC register.
- imem_instr  input  INSTR_W  instruction from memory, valid in the same cycle as imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_W  target PC, sampled when redirect_valid=1.
- out_valid  output  1  fetch buffer holds an instruction for decode.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_instr  output  INSTR_W  buffered instruction.
- out_pc  output  ADDR_W  address the buffered instruction was fetched from.
- halted  output  1  high while the FSM is in HALTED.
- pc_wrapped  output  1  sticky flag: the PC wrapped from 1023 to 0.
- instr_count  output  16  number of accepted transfers, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, pc = RESET_PC.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - halted = 0, pc_wrapped = 0, instr_count = 0.
- Transfer: a transfer occurs on any cycle with out_valid && out_ready. instr_count increments on each transfer unless already 16'hFFFF.
- FSM states: IDLE, RUN, HALTED.
- IDLE:
  - out_valid stays 0.
  - start=1 moves to RUN next cycle.
  - redirect_valid=1 loads pc <= redirect_pc and stays in IDLE.
- RUN, fetch condition: a fetch happens when redirect_valid=0 and (out_valid=0 or out_ready=1). On a fetch:
  - out_instr <= imem_instr, out_pc <= pc, out_valid <= 1.
  - pc <= pc+1, modulo 2^ADDR_W.
  - If pc = 1023, set pc_wrapped.
  - If imem_instr == HALT_INSTR, move to HALTED and leave pc at the HALT address + 1.
- RUN, backpressure: if out_valid=1 and out_ready=0, out_instr, out_pc and pc hold. No instruction is dropped or duplicated.
- RUN, no transfer: if out_valid=1 and out_ready=0 is false but no fetch occurs, out_valid <= 0 after the transfer.
- Latency:
  - start sampled at edge E0.
  - RUN begins after E0; first fetch at edge E1.
  - out_valid=1 with out_pc=RESET_PC in the cycle after E1.
  - With out_ready held at 1, throughput is one instruction per cycle.
- Redirect (any state; highest priority below reset):
  - pc <= redirect_pc, out_valid <= 0, pc_wrapped <= 0.
  - A transfer in the same cycle still counts; the buffered entry is consumed and no new fetch occurs that cycle.
  - Exactly one bubble, then fetching resumes from redirect_pc.
- Redirect state transitions: from HALTED, go to RUN; from IDLE, stay IDLE (start still required); from RUN, stay RUN.
- HALTED:
  - No fetches; halted=1.
  - The HALT instruction remains offered (out_valid=1) until accepted, then out_valid=0.
  - start is ignored; only redirect_valid or reset leaves HALTED.
- Simultaneous start and redirect in IDLE: pc <= redirect_pc and move to RUN; the first fetch is from redirect_pc.
- Reset mid-operation: all state returns to reset values immediately; any in-flight instruction is discarded.
- Counter widths: pc arithmetic uses ADDR_W bits; carry out is used only for pc_wrapped. instr_count never rolls over.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W constants.
  - HALT_INSTR and the opcode field positions [15:13].
  - The fetch_state_t enum {IDLE, RUN, HALTED}.
- Single module; no sub-module is warranted. The PC and fetch buffer stay in one always block, and the FSM next-state logic is in a separate combinational block.

Test Plan:
- Memory preloaded with 6 arithmetic words at 0–5 and HALT_INSTR at 6; out_ready=1; start pulse -> out_pc 0,1,2,...,6 on consecutive cycles with the matching words; then halted=1, out_valid=0, instr_count=7.
- Same program, out_ready=0 for 3 cycles while out_pc=2 -> out_instr/out_pc stay at word 2, imem_addr stays 3; after out_ready=1, out_pc sequence 3,4 continues with no skip or repeat.
- redirect_valid=1, redirect_pc=10'd100 while out_pc=3 is being accepted -> instr_count counts word 3, one cycle with out_valid=0, next out_pc=100.
- redirect_pc=10'd1022 with non-HALT words at 1022, 1023, 0 -> out_pc 1022, 1023, 0; pc_wrapped rises after the fetch from 1023; a later redirect clears it.
- In HALTED: start pulse -> no change; redirect_pc=10'd20 -> halted=0 next cycle, fetching resumes with out_pc=20.
- rst_n asserted low mid-stream (asynchronously, between edges) -> out_valid=0, halted=0, imem_addr=RESET_PC, instr_count=0 immediately; no fetch until a new start pulse.
